ship_placer: RTL and testbench

- Upstream loader for the per-player ship register (5 ships x 5 cell slots, 5-bit cell codes, code 0 = empty or hit).
- Walks the player through placing ships 0..numBarcos-1 in order, taking an anchor cell and an orientation for each ship.
- Checks each placement for board bounds and overlap, then writes the accepted cells into the ship register one slot per cycle.
- Asserts done when the fleet is complete.

---
 rtl/battleship_pkg.sv | 33 +++
 rtl/ship_occupancy_map.sv | 29 ++
 rtl/ship_placer.sv | 147 ++++++++++++++
 tb/tb_ship_placer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types, board defaults and cell helpers for the battleship placement logic.
package battleship_pkg;

  localparam int CELL_W          = 5;
  localparam int BOARD_ROWS_DEF  = 5;
  localparam int BOARD_COLS_DEF  = 5;
  localparam int MAX_SHIPS       = 5;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_POS,
    CHECK,
    WRITE,
    REJECT,
    DONE
  } placer_state_t;

  // Ship i occupies i+1 cells.
  function automatic logic [3:0] ship_len(input logic [2:0] idx);
    return {1'b0, idx} + 4'd1;
  endfunction

  // Code 0 is reserved for empty/hit, so live cells are numbered from 1.
  function automatic cell_t cell_code(input logic [3:0] row, input logic [3:0] col,
                                      input int cols);
    int c;
    c = int'(row) * cols + int'(col) + 1;
    return cell_t'(c);
  endfunction

endpackage

// File: rtl/ship_occupancy_map.sv
// One bit per board cell, indexed by cell code; clear wins over a same-cycle set.
module ship_occupancy_map
  import battleship_pkg::*;
#(
  parameter int N = BOARD_ROWS_DEF * BOARD_COLS_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  set_en,
  input  cell_t set_code,
  input  cell_t rd_code,
  output logic  occupied
);

  logic [N-1:0] occ;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ <= '0;
    end else if (set_en && set_code != '0) begin
      // NOTE: state registers take non-blocking assignments so every flop updates from pre-edge values.
      occ[set_code - cell_t'(1)] <= 1'b1;
    end
  end

  assign occupied = (rd_code != '0) && occ[rd_code - cell_t'(1)];

endmodule

// File: rtl/ship_placer.sv
// Fleet placement FSM: bounds check, per-cell overlap check, then one ship-register write per cycle.
module ship_placer
  import battleship_pkg::*;
#(
  parameter int numBarcos  = 5,
  parameter int BOARD_ROWS = BOARD_ROWS_DEF,
  parameter int BOARD_COLS = BOARD_COLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       place_req,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  input  logic       orient,
  output logic       wr_en,
  output logic [2:0] wr_ship,
  output logic [2:0] wr_slot,
  output logic [4:0] wr_cell,
  output logic [2:0] cur_ship,
  output logic       busy,
  output logic       reject,
  output logic       done
);

  localparam logic [3:0] ROWS4     = 4'(BOARD_ROWS);
  localparam logic [3:0] COLS4     = 4'(BOARD_COLS);
  localparam logic [2:0] LAST_SHIP = 3'(numBarcos - 1);

  placer_state_t state_q, state_d;
  logic [2:0] ship_q, ship_d;
  logic [2:0] k_q, k_d;
  logic [2:0] row_q, col_q;
  logic       orient_q;
  logic       latch_pos;

  logic [3:0] len;
  logic       last_k;
  logic [3:0] far_row, far_col;
  logic       in_bounds;
  logic [3:0] row_k, col_k;
  cell_t      cell_k;
  logic       occupied;

  assign len    = ship_len(ship_q);
  assign last_k = ({1'b0, k_q} == len - 4'd1);

  // Far end is formed at 4 bits so an anchor near 7 cannot wrap back onto the board.
  assign far_row   = {1'b0, cur_row} + (orient  ? len - 4'd1 : 4'd0);
  assign far_col   = {1'b0, cur_col} + (!orient ? len - 4'd1 : 4'd0);
  assign in_bounds = (far_row < ROWS4) && (far_col < COLS4);

  assign row_k  = {1'b0, row_q} + (orient_q  ? {1'b0, k_q} : 4'd0);
  assign col_k  = {1'b0, col_q} + (!orient_q ? {1'b0, k_q} : 4'd0);
  assign cell_k = cell_code(row_k, col_k, BOARD_COLS);

  ship_occupancy_map #(.N(BOARD_ROWS * BOARD_COLS)) u_map (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .set_en   (state_q == WRITE),
    .set_code (cell_k),
    .rd_code  (cell_k),
    .occupied (occupied)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    ship_d    = ship_q;
    k_d       = k_q;
    latch_pos = 1'b0;
    if (start) begin
      state_d = WAIT_POS;
      ship_d  = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_POS: begin
          if (place_req) begin
            latch_pos = 1'b1;
            k_d       = '0;
            state_d   = in_bounds ? CHECK : REJECT;
          end
        end
        CHECK: begin
          if (occupied) begin
            state_d = REJECT;
          end else if (last_k) begin
            state_d = WRITE;
            k_d     = '0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        WRITE: begin
          if (last_k) begin
            k_d = '0;
            if (ship_q == LAST_SHIP) begin
              state_d = DONE;
            end else begin
              ship_d  = ship_q + 3'd1;
              state_d = WAIT_POS;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        REJECT:  state_d = WAIT_POS;
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ship_q   <= '0;
      k_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      orient_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ship_q  <= ship_d;
      k_q     <= k_d;
      if (latch_pos) begin
        row_q    <= cur_row;
        col_q    <= cur_col;
        orient_q <= orient;
      end
    end
  end

  // A write cycle already on the outputs when start arrives completes; the map clear wins over its set.
  assign wr_en    = (state_q == WRITE);
  assign wr_ship  = wr_en ? ship_q : 3'd0;
  assign wr_slot  = wr_en ? k_q : 3'd0;
  assign wr_cell  = wr_en ? cell_k : 5'd0;
  assign cur_ship = ship_q;
  assign busy     = (state_q == CHECK) || (state_q == WRITE);
  assign reject   = (state_q == REJECT);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ship_placer.sv
// Directed bench for ship_placer: full five-ship fleet, rejects, restart, and a one-ship build.
module tb_ship_placer;

  logic       clk = 1'b0;
  logic       rst, start, place_req, orient;
  logic [2:0] cur_row, cur_col;
  logic       wr_en, busy, reject, done;
  logic [2:0] wr_ship, wr_slot, cur_ship;
  logic [4:0] wr_cell;

  logic       rst1, start1, place_req1, orient1;
  logic [2:0] cur_row1, cur_col1;
  logic       wr_en1, busy1, reject1, done1;
  logic [2:0] wr_ship1, wr_slot1, cur_ship1;
  logic [4:0] wr_cell1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] log_ship [16];
  logic [2:0] log_slot [16];
  logic [4:0] log_cell [16];
  logic       stray;

  always #5 clk = ~clk;

  ship_placer dut (
    .clk(clk), .rst(rst), .start(start), .place_req(place_req),
    .cur_row(cur_row), .cur_col(cur_col), .orient(orient),
    .wr_en(wr_en), .wr_ship(wr_ship), .wr_slot(wr_slot), .wr_cell(wr_cell),
    .cur_ship(cur_ship), .busy(busy), .reject(reject), .done(done)
  );

  ship_placer #(.numBarcos(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .place_req(place_req1),
    .cur_row(cur_row1), .cur_col(cur_col1), .orient(orient1),
    .wr_en(wr_en1), .wr_ship(wr_ship1), .wr_slot(wr_slot1), .wr_cell(wr_cell1),
    .cur_ship(cur_ship1), .busy(busy1), .reject(reject1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one place_req and follow the DUT until it leaves CHECK/WRITE/REJECT.
  task automatic run_place(input logic [2:0] r, input logic [2:0] c, input logic o,
                           output int n_chk, output int n_wr, output int n_rej);
    n_chk = 0;
    n_wr  = 0;
    n_rej = 0;
    stray = 1'b0;
    cur_row = r;
    cur_col = c;
    orient  = o;
    place_req = 1'b1;
    tick();
    place_req = 1'b0;
    for (int i = 0; i < 20 && (busy || reject); i++) begin
      if (reject) n_rej++;
      if (wr_en) begin
        log_ship[n_wr] = wr_ship;
        log_slot[n_wr] = wr_slot;
        log_cell[n_wr] = wr_cell;
        n_wr++;
      end else begin
        if (busy) n_chk++;
        if (wr_ship != 3'd0 || wr_slot != 3'd0 || wr_cell != 5'd0) stray = 1'b1;
      end
      tick();
    end
    check("settled", {30'd0, busy, reject}, 32'd0);
    check("idle_wr_fields_zero", {31'd0, stray}, 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [2:0] ship, input int n,
                              input int c0, input int c1, input int c2, input int c3, input int c4);
    int ec[5];
    ec = '{c0, c1, c2, c3, c4};
    for (int i = 0; i < n; i++) begin
      check({tag, "_ship"}, 32'(log_ship[i]), 32'(ship));
      check({tag, "_slot"}, 32'(log_slot[i]), 32'(i));
      check({tag, "_cell"}, 32'(log_cell[i]), 32'(ec[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nc, nw, nr;
    logic seen;

    rst = 1'b1; start = 1'b0; place_req = 1'b0; cur_row = '0; cur_col = '0; orient = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; place_req1 = 1'b0; cur_row1 = '0; cur_col1 = '0; orient1 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst1 = 1'b0;
    tick();

    check("reset_outputs", {wr_en, wr_ship, wr_slot, wr_cell, cur_ship, busy, reject, done}, 32'd0);

    // place_req in IDLE is ignored
    place_req = 1'b1; tick(); place_req = 1'b0;
    check("idle_ignores_place", {busy, reject, wr_en, cur_ship}, 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_cur_ship", cur_ship, 0);

    // ship 0 at (0,0) horizontal
    run_place(3'd0, 3'd0, 1'b0, nc, nw, nr);
    check("s0_chk", nc, 1); check("s0_wr", nw, 1); check("s0_rej", nr, 0);
    check_writes("s0", 3'd0, 1, 1, 0, 0, 0, 0);
    check("s0_cur_ship", cur_ship, 1);

    // ship 1 at (0,0): overlap on cell 1 at k=0
    run_place(3'd0, 3'd0, 1'b0, nc, nw, nr);
    check("s1_ovl_chk", nc, 1); check("s1_ovl_wr", nw, 0); check("s1_ovl_rej", nr, 1);
    check("s1_ovl_cur_ship", cur_ship, 1);

    // ship 1 at (1,4): far column 5 out of bounds, no CHECK cycles
    run_place(3'd1, 3'd4, 1'b0, nc, nw, nr);
    check("s1_oob_chk", nc, 0); check("s1_oob_rej", nr, 1); check("s1_oob_wr", nw, 0);

    run_place(3'd1, 3'd3, 1'b0, nc, nw, nr);
    check("s1_chk", nc, 2); check("s1_wr", nw, 2);
    check_writes("s1", 3'd1, 2, 9, 10, 0, 0, 0);
    check("s1_cur_ship", cur_ship, 2);

    // ship 2 at (2,0) vertical
    run_place(3'd2, 3'd0, 1'b1, nc, nw, nr);
    check("s2_chk", nc, 3); check("s2_wr", nw, 3);
    check_writes("s2", 3'd2, 3, 11, 16, 21, 0, 0);

    // ship 3 vertical at (3,1): far row 6 out of bounds
    run_place(3'd3, 3'd1, 1'b1, nc, nw, nr);
    check("s3_oob_chk", nc, 0); check("s3_oob_rej", nr, 1);

    // ship 3 vertical at (0,4): cell 5 free, cell 10 taken at k=1
    run_place(3'd0, 3'd4, 1'b1, nc, nw, nr);
    check("s3_ovl_chk", nc, 2); check("s3_ovl_rej", nr, 1); check("s3_ovl_wr", nw, 0);

    run_place(3'd0, 3'd1, 1'b1, nc, nw, nr);
    check("s3_wr", nw, 4);
    check_writes("s3", 3'd3, 4, 2, 7, 12, 17, 0);

    // ship 4 at (4,0) horizontal collides with ship 2 at cell 21
    run_place(3'd4, 3'd0, 1'b0, nc, nw, nr);
    check("s4_ovl_chk", nc, 1); check("s4_ovl_rej", nr, 1);
    check("s4_ovl_not_done", done, 0);

    run_place(3'd0, 3'd2, 1'b1, nc, nw, nr);
    check("s4_chk", nc, 5); check("s4_wr", nw, 5);
    check_writes("s4", 3'd4, 5, 3, 8, 13, 18, 23);
    check("fleet_done", done, 1);

    // place_req in DONE is ignored
    seen = 1'b0;
    cur_row = 3'd1; cur_col = 3'd1; orient = 1'b0;
    place_req = 1'b1; tick(); place_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wr_en || busy || reject || !done) seen = 1'b1;
      tick();
    end
    check("done_ignores_place", {31'd0, seen}, 32'd0);

    // restart from DONE, then abandon ship 2's write at slot 1
    start = 1'b1; tick(); start = 1'b0;
    check("restart_done_clr", done, 0);
    check("restart_cur_ship", cur_ship, 0);
    run_place(3'd0, 3'd0, 1'b0, nc, nw, nr);
    check("r_s0_wr", nw, 1);
    run_place(3'd1, 3'd3, 1'b0, nc, nw, nr);
    check("r_s1_wr", nw, 2);
    cur_row = 3'd2; cur_col = 3'd0; orient = 1'b1;
    place_req = 1'b1; tick(); place_req = 1'b0;
    tick(); tick(); tick();
    check("r_s2_slot0", {wr_en, wr_slot, wr_cell}, {23'd0, 1'b1, 3'd0, 5'd11});
    tick();
    check("r_s2_slot1", {wr_en, wr_slot, wr_cell}, {23'd0, 1'b1, 3'd1, 5'd16});
    start = 1'b1; tick(); start = 1'b0;
    check("abort_state", {wr_en, busy, done, cur_ship}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wr_en) seen = 1'b1;
      tick();
    end
    check("abort_no_wr", {31'd0, seen}, 32'd0);
    run_place(3'd0, 3'd0, 1'b0, nc, nw, nr);
    check("after_abort_s0_wr", nw, 1); check("after_abort_s0_rej", nr, 0);
    check_writes("after_abort_s0", 3'd0, 1, 1, 0, 0, 0, 0);
    // cells 11 and 16 must be free again
    run_place(3'd2, 3'd0, 1'b1, nc, nw, nr);
    check("after_abort_s1_wr", nw, 2);
    check_writes("after_abort_s1", 3'd1, 2, 11, 16, 0, 0, 0);

    // single-ship build
    start1 = 1'b1; tick(); start1 = 1'b0;
    cur_row1 = 3'd0; cur_col1 = 3'd7; orient1 = 1'b0;
    place_req1 = 1'b1; tick(); place_req1 = 1'b0;
    check("one_col7_reject", {busy1, reject1}, 32'd1);
    tick();
    check("one_reject_pulse", reject1, 0);
    cur_row1 = 3'd4; cur_col1 = 3'd4;
    place_req1 = 1'b1; tick(); place_req1 = 1'b0;
    check("one_check", {busy1, wr_en1}, 32'd2);
    tick();
    check("one_write", {wr_en1, wr_ship1, wr_slot1, wr_cell1}, {20'd0, 1'b1, 3'd0, 3'd0, 5'd25});
    tick();
    check("one_done", {done1, wr_en1, busy1}, 32'd4);

    start1 = 1'b1; tick(); start1 = 1'b0;
    check("one_restart", {done1, cur_ship1}, 32'd0);
    place_req1 = 1'b1; tick(); place_req1 = 1'b0;
    check("one_check2", busy1, 1);
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    check("one_rst_outputs",
          {wr_en1, wr_ship1, wr_slot1, wr_cell1, cur_ship1, busy1, reject1, done1}, 32'd0);
    place_req1 = 1'b1; tick(); place_req1 = 1'b0;
    check("one_idle_ignores", {busy1, reject1, wr_en1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
